data_mem_port: RTL and testbench
================================

DATA_MEM_PORT -- requirements
Module: data_mem_port

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUS-state cycles waiting for bus_ready before abort (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1, core requests an access.
REQ-005 SHALL have port req_ready, output, 1, block accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32 (addr_t), byte address.
REQ-008 SHALL have port req_wdata, input, 32 (data_t), store data already shifted into its byte lanes.
REQ-009 SHALL have port req_byte_en, input, 4, lane enables from the load/store formatter.
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-011 SHALL have port rsp_rdata, output, 32, raw read word for the load formatter.
REQ-012 SHALL have port rsp_error, output, 1, access failed (illegal enables or timeout).
REQ-013 SHALL have ports bus_valid (out, 1), bus_write (out, 1), bus_addr (out, 32), bus_wdata (out, 32) and bus_be (out, 4), the memory-side request.
REQ-014 SHALL have ports bus_ready (in, 1), meaning the memory completes the access, and bus_rdata (in, 32), meaning read data valid with bus_ready.

Function
REQ-015 SHALL implement states IDLE, BUS and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL, in IDLE with req_valid=1, register req_write, req_addr, req_wdata and req_byte_en, then change state on the next edge.
REQ-018 SHALL treat req_byte_en values 0001, 0010, 0100, 1000, 0011, 1100 and 1111 as legal; any other value goes IDLE->RESP with rsp_error=1 and no bus cycle.
REQ-019 SHALL, for a legal request, go IDLE->BUS.
REQ-020 SHALL, in BUS, hold bus_valid=1 and drive bus_write, bus_wdata and bus_be from the registered request, stable until completion.
REQ-021 SHALL drive bus_addr = {req_addr[31:2], 2'b00}.
REQ-022 SHALL count BUS cycles with bus_ready=0 using an 8-bit wait counter, cleared on BUS entry.
REQ-023 SHALL, on bus_ready=1 in BUS, capture bus_rdata for loads (32'h0 for stores), set error=0 and go to RESP.
REQ-024 SHALL, when the wait counter reaches TIMEOUT_CYCLES-1 with bus_ready=0, go to RESP with rsp_error=1 and rsp_rdata=0.
REQ-025 SHALL give bus_ready priority over timeout when both occur in the same cycle (normal completion).
REQ-026 SHALL, in RESP, assert rsp_valid for exactly one cycle with registered rsp_rdata and rsp_error, then return to IDLE.
REQ-027 SHALL meet this latency: request accepted at edge N; bus_valid high from cycle N+1; bus_ready seen at edge M; rsp_valid in cycle M+1.
REQ-028 SHALL accept a new request no earlier than the cycle after rsp_valid; back-to-back requests are spaced at least 3 cycles apart.
REQ-029 SHALL keep bus_valid=0 outside BUS and rsp_valid=0 outside RESP.
REQ-030 SHALL hold rsp_rdata and rsp_error at their last values outside RESP.

Reset
REQ-031 SHALL, on reset=1 regardless of clk, force state IDLE, wait counter 0 and all outputs 0 (req_ready=1 once reset deasserts).
REQ-032 SHALL, on reset during BUS, drop bus_valid asynchronously and produce no response for the aborted access.

Verification
REQ-033 SHALL cover a load: addr 0x104, be 1111, bus_ready after 2 wait cycles with rdata 0xDEADBEEF -> bus_addr 0x104, rsp_valid one cycle, rsp_rdata 0xDEADBEEF, rsp_error 0.
REQ-034 SHALL cover a store: addr 0x203, be 1000, wdata 0xAB000000, immediate bus_ready -> bus_addr 0x200, bus_be 1000, bus_write 1, rsp_rdata 0, rsp_error 0, rsp_valid 2 cycles after acceptance.
REQ-035 SHALL cover illegal enables: be 0110 -> bus_valid never asserted, rsp_valid next cycle with rsp_error 1.
REQ-036 SHALL cover timeout: TIMEOUT_CYCLES=16, bus_ready held 0 -> bus_valid high 16 cycles, then rsp_error 1, rsp_rdata 0; bus_ready pulsed at the 16th cycle -> normal completion.
REQ-037 SHALL cover reset mid-BUS: reset at the 3rd BUS cycle -> bus_valid 0 the same cycle, no rsp_valid, next request serviced normally.
REQ-038 SHALL cover back-to-back: req_valid held high with two loads -> second accepted the cycle after first rsp_valid, req_ready low in between.

Source files
------------

// File: rtl/data_mem_port.sv
// -----------------------------------------------------------------------------
// data_mem_port
//
// Single-outstanding data memory port between a core's load/store unit and a
// simple valid/ready memory bus. One request is accepted in IDLE, issued on the
// bus in BUS (bounded by a wait-cycle timeout), and answered with a one-cycle
// response strobe in RESP. Byte-enable patterns that do not match a naturally
// aligned byte, halfword or word are answered with an error and no bus cycle.
//
// Parameters
//   TIMEOUT_CYCLES  max BUS cycles without bus_ready before abort (2..255)
//
// Ports
//   clk, reset                       clock, async active-high reset
//   req_valid/req_ready              core request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata,
//   req_byte_en                      request attributes
//   rsp_valid, rsp_rdata, rsp_error  one-cycle response, data/error held after
//   bus_valid, bus_write, bus_addr,
//   bus_wdata, bus_be                memory-side request (word-aligned address)
//   bus_ready, bus_rdata             memory completion and load data
// -----------------------------------------------------------------------------
module data_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        bus_valid,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        r_write;
  logic [29:0] r_addr_word;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;

  logic        accept;
  logic        be_ok;
  logic        bus_done;
  logic        bus_timeout;

  // Only naturally aligned byte, halfword and word lane patterns are legal.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  assign accept      = (state == S_IDLE) && req_valid;
  assign be_ok       = be_legal(req_byte_en);
  // bus_ready wins over the timeout when both land in the same cycle.
  assign bus_done    = (state == S_BUS) && bus_ready;
  assign bus_timeout = (state == S_BUS) && !bus_ready && (wait_cnt == WAIT_LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = be_ok ? S_BUS : S_RESP;
      S_BUS:  if (bus_done || bus_timeout) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: the request and response registers are reset (not left to power-up
  // values) because they drive module outputs that must read 0 during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= 8'd0;
      r_write     <= 1'b0;
      r_addr_word <= 30'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            r_write     <= req_write;
            r_addr_word <= req_addr[31:2];
            r_wdata     <= req_wdata;
            r_be        <= req_byte_en;
            wait_cnt    <= 8'd0;
            // Illegal lanes skip the bus; the response is known right now.
            if (!be_ok) begin
              rsp_rdata_q <= 32'd0;
              rsp_error_q <= 1'b1;
            end
          end
        end
        S_BUS: begin
          if (bus_done) begin
            rsp_rdata_q <= r_write ? 32'd0 : bus_rdata;
            rsp_error_q <= 1'b0;
          end else if (bus_timeout) begin
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // req_ready is also gated by reset so it reads 0 while reset is held.
  assign req_ready = (state == S_IDLE) && !reset;
  assign bus_valid = (state == S_BUS);
  assign bus_write = r_write;
  assign bus_addr  = {r_addr_word, 2'b00};
  assign bus_wdata = r_wdata;
  assign bus_be    = r_be;
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_port.sv
// -----------------------------------------------------------------------------
// tb_data_mem_port
//
// Self-checking bench for data_mem_port. A driver issues requests; for every
// request the expected response (data, error, latency) goes into exp_q and,
// for requests that should reach the bus, a bus plan (fields, wait cycles,
// read data) goes into plan_q. A bus model pops plans, answers the bus and
// checks the bus-side fields; a response monitor pops exp_q on rsp_valid.
// -----------------------------------------------------------------------------
module tb_data_mem_port;

  localparam int T = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    int          w;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } plan_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_byte_en = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  int total = 0;
  int bad   = 0;

  exp_t  exp_q[$];
  plan_t plan_q[$];

  data_mem_port #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_byte_en(req_byte_en),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .bus_valid  (bus_valid),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal lane patterns: aligned byte, halfword, word.
  function automatic bit legal_be(input logic [3:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  // Bus cycles seen for a given number of bus_ready=0 cycles before ready.
  function automatic int bus_cycles(input int w);
    return (w + 1 < T) ? w + 1 : T;
  endfunction

  // Issue one request. w = bus_ready=0 cycles the memory inserts; rd = load data.
  // keep=1 leaves req_valid high afterwards (back-to-back traffic).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int w, input logic [31:0] rd,
                        input bit keep);
    exp_t  e;
    plan_t p;
    int    n;
    bit    ok;
    ok = legal_be(be);
    e.err   = !ok || (w >= T);
    e.rdata = (e.err || wr) ? 32'h0 : rd;
    e.lat   = ok ? bus_cycles(w) + 1 : 1;
    exp_q.push_back(e);
    if (ok) begin
      p.w = w; p.write = wr; p.addr = addr; p.wdata = wd; p.be = be; p.rdata = rd;
      plan_q.push_back(p);
    end
    if (!req_valid) begin
      @(posedge clk); #1;
    end
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wd;
    req_byte_en = be;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_accept", req_ready, 1'b1);
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
  endtask

  // Bus model: answers the bus per plan and checks bus-side fields.
  initial begin : bus_model
    int    cnt = 0;
    plan_t cur;
    cur = '{w: 0, write: 1'b0, addr: 32'h0, wdata: 32'h0, be: 4'h0, rdata: 32'h0};
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end else if (bus_valid) begin
        if (cnt == 0) begin
          check("bus_expected", plan_q.size() != 0, 1'b1);
          if (plan_q.size() != 0) cur = plan_q.pop_front();
        end
        check("bus_addr",  bus_addr,  {cur.addr[31:2], 2'b00});
        check("bus_write", bus_write, cur.write);
        check("bus_wdata", bus_wdata, cur.wdata);
        check("bus_be",    bus_be,    cur.be);
        bus_ready = (cnt == cur.w);
        bus_rdata = (bus_ready && !cur.write) ? cur.rdata : $urandom;
        cnt++;
      end else begin
        if (cnt != 0) check("bus_cycles", cnt, bus_cycles(cur.w));
        cnt = 0;
        bus_ready = 1'b0;
        bus_rdata = $urandom;
      end
    end
  end

  // Response monitor: handshake, latency, one-cycle strobe, held values.
  initial begin : rsp_monitor
    bit          busy = 0;
    int          lat = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy = 0; lat = 0; last_rdata = '0; last_err = 1'b0;
        continue;
      end
      check("req_ready", req_ready, !busy);
      check("rsp_bus_excl", rsp_valid && bus_valid, 1'b0);
      if (req_valid && req_ready) begin
        busy = 1; lat = 0;
      end else if (busy) begin
        lat++;
      end
      if (rsp_valid) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_rdata",   rsp_rdata, e.rdata);
          check("rsp_error",   rsp_error, e.err);
          check("rsp_latency", lat, e.lat);
        end
        busy = 0;
        last_rdata = rsp_rdata;
        last_err   = rsp_error;
      end else begin
        check("rsp_rdata_hold", rsp_rdata, last_rdata);
        check("rsp_error_hold", rsp_error, last_err);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] be;
    int         w;
    int         n;
    reset = 1'b1;
    #3;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_bus_valid", bus_valid, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_error", rsp_error, 1'b0);
    check("rst_bus_addr",  bus_addr,  32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_req_ready", req_ready, 1'b1);

    // Load, two wait cycles.
    do_req(1'b0, 32'h0000_0104, 32'h0, 4'b1111, 2, 32'hDEAD_BEEF, 0);
    // Store to top byte lane, immediate ready.
    do_req(1'b1, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 0, 32'h1234_5678, 0);
    // Illegal lanes: no bus cycle, error next cycle.
    do_req(1'b0, 32'h0000_0300, 32'h0, 4'b0110, 0, 32'h0, 0);
    // Timeout, ready on the last allowed cycle, and a long stall.
    do_req(1'b0, 32'h0000_0400, 32'h0, 4'b1111, T, 32'hCAFE_F00D, 0);
    do_req(1'b0, 32'h0000_0404, 32'h0, 4'b0011, T - 1, 32'h0BAD_CAFE, 0);
    do_req(1'b1, 32'h0000_0408, 32'h5555_0000, 4'b1100, T + 9, 32'h0, 0);

    // Reset asserted in the 3rd BUS cycle of a stalled load.
    do_req(1'b0, 32'h0000_0500, 32'h0, 4'b1111, 10, 32'h7777_7777, 0);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_bus_valid", bus_valid, 1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    exp_q.delete();
    plan_q.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    do_req(1'b0, 32'h0000_0504, 32'h0, 4'b0001, 1, 32'h0000_00A5, 0);

    // Back-to-back loads with req_valid held high.
    do_req(1'b0, 32'h0000_0600, 32'h0, 4'b1111, 0, 32'h1111_2222, 1);
    do_req(1'b0, 32'h0000_0604, 32'h0, 4'b1111, 1, 32'h3333_4444, 0);

    // Randomized traffic.
    repeat (60) begin
      if ($urandom_range(0, 4) == 0) be = 4'($urandom);
      else begin
        case ($urandom_range(0, 6))
          0: be = 4'b0001; 1: be = 4'b0010; 2: be = 4'b0100; 3: be = 4'b1000;
          4: be = 4'b0011; 5: be = 4'b1100; default: be = 4'b1111;
        endcase
      end
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(T - 3, T + 3) : $urandom_range(0, 3);
      do_req(1'($urandom), $urandom, $urandom, be, w, $urandom, 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    check("exp_q_drained",  exp_q.size(),  0);
    check("plan_q_drained", plan_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
